// File: rtl/gpio_bank_pkg.sv
// Shared register-map constants for the GPIO bank.
package gpio_bank_pkg;
   typedef logic [2:0] gpio_addr_t;

   localparam gpio_addr_t ADDR_DIR     = 3'd0;
   localparam gpio_addr_t ADDR_OUT     = 3'd1;
   localparam gpio_addr_t ADDR_IN      = 3'd2;
   localparam gpio_addr_t ADDR_RISE_EN = 3'd3;
   localparam gpio_addr_t ADDR_FALL_EN = 3'd4;
   localparam gpio_addr_t ADDR_STATUS  = 3'd5;
   localparam gpio_addr_t ADDR_OUT_SET = 3'd6;
   localparam gpio_addr_t ADDR_OUT_CLR = 3'd7;
endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input bit: 2-FF synchroniser followed by an optional stable-count debouncer.
module gpio_debounce #(
   parameter int DEB_CYCLES = 0
) (
   input  logic CK,
   input  logic RSTN,
   input  logic pin_i,
   output logic deb_o
);
   localparam int CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (DEB_CYCLES == 0) begin
         deb_d = sync2_q;
      end else if (sync2_q != deb_q) begin
         // Accept only after the new level has persisted DEB_CYCLES samples.
         if (cnt_q == CNT_MAX) deb_d = sync2_q;
         else                  cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign deb_o = deb_q;
endmodule

// File: rtl/gpio_bank.sv
// Tristate GPIO bank: direction/output registers, atomic set/clear, synchronised
// debounced inputs, sticky edge status and a level interrupt on a simple register bus.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               DEB_CYCLES = 0,
   parameter logic [WIDTH-1:0] OUT_RESET  = '0
) (
   input  logic             CK,
   input  logic             RSTN,
   inout  wire  [WIDTH-1:0] GPIO,
   input  gpio_addr_t       Addr,
   input  logic             WrEn,
   input  logic [WIDTH-1:0] WrData,
   input  logic             RdEn,
   output logic [WIDTH-1:0] RdData,
   output logic             Irq
);
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] status_q, status_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] deb_dly_q;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] deb_in;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] rd_mux;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign GPIO[i] = dir_q[i] ? out_q[i] : 1'bz;

      // Pads are sampled regardless of direction so driven outputs loop back into IN.
      gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .CK    (CK),
         .RSTN  (RSTN),
         .pin_i (GPIO[i]),
         .deb_o (deb_in[i])
      );
   end

   always_comb begin
      edge_hit = ((deb_in & ~deb_dly_q) & rise_en_q) | ((~deb_in & deb_dly_q) & fall_en_q);

      dir_d     = dir_q;
      out_d     = out_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      status_d  = status_q | edge_hit;
      irq_d     = |status_q;

      if (WrEn) begin
         case (Addr)
            ADDR_DIR:     dir_d     = WrData;
            ADDR_OUT:     out_d     = WrData;
            ADDR_RISE_EN: rise_en_d = WrData;
            ADDR_FALL_EN: fall_en_d = WrData;
            // A fresh edge overrides a simultaneous clear of the same bit.
            ADDR_STATUS:  status_d  = (status_q & ~WrData) | edge_hit;
            ADDR_OUT_SET: out_d     = out_q | WrData;
            ADDR_OUT_CLR: out_d     = out_q & ~WrData;
            default:      ;
         endcase
      end

      case (Addr)
         ADDR_DIR:     rd_mux = dir_q;
         ADDR_OUT:     rd_mux = out_q;
         ADDR_IN:      rd_mux = deb_in;
         ADDR_RISE_EN: rd_mux = rise_en_q;
         ADDR_FALL_EN: rd_mux = fall_en_q;
         ADDR_STATUS:  rd_mux = status_q;
         default:      rd_mux = '0;
      endcase
      rdata_d = RdEn ? rd_mux : rdata_q;
   end

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         dir_q     <= '0;
         out_q     <= OUT_RESET;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         rdata_q   <= '0;
         deb_dly_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         dir_q     <= dir_d;
         out_q     <= out_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         rdata_q   <= rdata_d;
         deb_dly_q <= deb_in;
         irq_q     <= irq_d;
      end
   end

   assign RdData = rdata_q;
   assign Irq    = irq_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard-driven bench for gpio_bank: register map, pad drive, debounce, edge status, async reset.
module tb_gpio_bank;
   import gpio_bank_pkg::*;

   localparam int W   = 32;
   localparam int DEB = 4;

   logic         CK   = 1'b0;
   logic         RSTN = 1'b1;
   wire  [W-1:0] GPIO;
   gpio_addr_t   Addr   = '0;
   logic         WrEn   = 1'b0;
   logic [W-1:0] WrData = '0;
   logic         RdEn   = 1'b0;
   logic [W-1:0] RdData;
   logic         Irq;

   logic [W-1:0] tb_drv = '0;
   logic [W-1:0] tb_oe  = '1;

   int total = 0;
   int bad   = 0;
   logic [W:0] exp_q[$];

   always #5 CK = ~CK;

   for (genvar i = 0; i < W; i++) begin : g_pin
      assign GPIO[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
   end

   gpio_bank #(.WIDTH(W), .DEB_CYCLES(DEB), .OUT_RESET('0)) dut (
      .CK     (CK),
      .RSTN   (RSTN),
      .GPIO   (GPIO),
      .Addr   (Addr),
      .WrEn   (WrEn),
      .WrData (WrData),
      .RdEn   (RdEn),
      .RdData (RdData),
      .Irq    (Irq)
   );

   task automatic bus_write(input gpio_addr_t a, input logic [W-1:0] d);
      @(negedge CK);
      Addr = a; WrData = d; WrEn = 1'b1;
      @(negedge CK);
      WrEn = 1'b0;
   endtask

   task automatic bus_read(input gpio_addr_t a, output logic [W-1:0] d);
      @(negedge CK);
      Addr = a; RdEn = 1'b1;
      @(negedge CK);
      RdEn = 1'b0;
      d = RdData;
   endtask

   task automatic test_reset();
      logic [W-1:0] got;
      logic [W:0]   e;
      #1 RSTN = 1'b0;
      #1;
      total++;
      if (Irq !== 1'b0 || RdData !== '0) begin
         bad++; $display("FAIL reset_outputs got Irq=%b RdData=%h exp 0/0", Irq, RdData);
      end
      repeat (2) @(negedge CK);
      RSTN = 1'b1;
      for (int a = 0; a < 8; a++) begin
         exp_q.push_back('0);
         bus_read(gpio_addr_t'(a), got);
         e = exp_q.pop_front();
         total++;
         if (got !== e[W-1:0]) begin
            bad++; $display("FAIL reset_reg%0d got=%h exp=%h", a, got, e[W-1:0]);
         end
      end
   endtask

   task automatic test_drive();
      logic [W-1:0] got;
      logic [W:0]   e;
      bus_write(ADDR_DIR, 32'h0000_00FF);
      tb_oe  = ~32'h0000_00FF;
      tb_drv = 32'h1234_5600;
      bus_write(ADDR_OUT, 32'h0000_00A5);
      total++;
      if (GPIO[7:0] !== 8'hA5) begin
         bad++; $display("FAIL drive_low got=%h exp=a5", GPIO[7:0]);
      end
      total++;
      if (GPIO[31:8] !== 24'h123456) begin
         bad++; $display("FAIL drive_hiz got=%h exp=123456", GPIO[31:8]);
      end
      repeat (8) @(negedge CK);
      exp_q.push_back({1'b0, 32'h1234_56A5});
      bus_read(ADDR_IN, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL drive_in got=%h exp=%h", got, e[W-1:0]);
      end
   endtask

   task automatic test_set_clear();
      logic [W-1:0] got;
      logic [W:0]   e;
      bus_write(ADDR_OUT, 32'h0F);
      bus_write(ADDR_OUT_SET, 32'hF0);
      exp_q.push_back({1'b0, 32'hFF});
      bus_read(ADDR_OUT, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL out_set got=%h exp=%h", got, e[W-1:0]);
      end
      bus_write(ADDR_OUT_CLR, 32'h03);
      total++;
      if (GPIO[7:0] !== 8'hFC) begin
         bad++; $display("FAIL out_clr_pad got=%h exp=fc", GPIO[7:0]);
      end
      bus_write(ADDR_IN, 32'hFFFF_FFFF);
      exp_q.push_back({1'b0, 32'hFC});
      exp_q.push_back({1'b0, 32'hFF});
      exp_q.push_back('0);
      bus_read(ADDR_OUT, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL out_clr got=%h exp=%h", got, e[W-1:0]);
      end
      bus_read(ADDR_DIR, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL ro_write_dir got=%h exp=%h", got, e[W-1:0]);
      end
      bus_read(ADDR_OUT_SET, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL wo_read got=%h exp=%h", got, e[W-1:0]);
      end
   endtask

   task automatic test_debounce();
      logic [W:0] e;
      bus_write(ADDR_DIR, '0);
      tb_oe  = '1;
      tb_drv = 32'h1234_5600;
      repeat (10) @(negedge CK);
      for (int j = 0; j < 17; j++) begin
         @(negedge CK);
         if (j > 0) begin
            e = exp_q.pop_front();
            total++;
            if (RdData[3] !== e[0]) begin
               bad++; $display("FAIL debounce_cyc%0d got=%b exp=%b", j, RdData[3], e[0]);
            end
         end
         tb_drv[3] = (j < 3) ? 1'b1 : (j < 5) ? 1'b0 : 1'b1;
         Addr = ADDR_IN; RdEn = 1'b1;
         exp_q.push_back({32'b0, (j + 1 >= 12)});
      end
      @(negedge CK);
      RdEn = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (RdData[3] !== e[0]) begin
         bad++; $display("FAIL debounce_final got=%b exp=%b", RdData[3], e[0]);
      end
   endtask

   task automatic test_edge_irq();
      logic [W-1:0] got;
      logic [W:0]   e;
      tb_drv[1] = 1'b1;
      repeat (10) @(negedge CK);
      bus_write(ADDR_RISE_EN, 32'h1);
      bus_write(ADDR_FALL_EN, 32'h2);
      for (int j = 0; j < 11; j++) begin
         if (j > 0) begin
            e = exp_q.pop_front();
            total++;
            if (RdData !== e[W-1:0] || Irq !== e[W]) begin
               bad++; $display("FAIL edge_cyc%0d got status=%h irq=%b exp status=%h irq=%b", j, RdData, Irq, e[W-1:0], e[W]);
            end
         end
         if (j == 0) begin
            tb_drv[0] = 1'b1;
            tb_drv[1] = 1'b0;
         end
         Addr = ADDR_STATUS; RdEn = 1'b1;
         exp_q.push_back((j + 1 >= 8) ? {1'b1, 32'h3} : '0);
         @(negedge CK);
      end
      RdEn = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (RdData !== e[W-1:0] || Irq !== e[W]) begin
         bad++; $display("FAIL edge_final got status=%h irq=%b exp status=%h irq=%b", RdData, Irq, e[W-1:0], e[W]);
      end
      bus_write(ADDR_STATUS, 32'h1);
      exp_q.push_back({1'b1, 32'h2});
      bus_read(ADDR_STATUS, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0] || Irq !== e[W]) begin
         bad++; $display("FAIL w1c_bit0 got status=%h irq=%b exp status=%h irq=%b", got, Irq, e[W-1:0], e[W]);
      end
      bus_write(ADDR_STATUS, 32'h2);
      total++;
      if (Irq !== 1'b1) begin
         bad++; $display("FAIL irq_lag got=%b exp=1", Irq);
      end
      @(negedge CK);
      total++;
      if (Irq !== 1'b0) begin
         bad++; $display("FAIL irq_clear got=%b exp=0", Irq);
      end
   endtask

   task automatic test_collision();
      logic [W-1:0] got;
      logic [W:0]   e;
      tb_drv[0] = 1'b0;
      repeat (10) @(negedge CK);
      exp_q.push_back('0);
      bus_read(ADDR_STATUS, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL disabled_edge got=%h exp=%h", got, e[W-1:0]);
      end
      @(negedge CK);
      tb_drv[0] = 1'b1;
      repeat (6) @(negedge CK);
      Addr = ADDR_STATUS; WrData = 32'h1; WrEn = 1'b1;
      @(negedge CK);
      WrEn = 1'b0;
      exp_q.push_back({1'b0, 32'h1});
      bus_read(ADDR_STATUS, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL collision got=%h exp=%h", got, e[W-1:0]);
      end
      bus_write(ADDR_RISE_EN, '0);
      exp_q.push_back({1'b1, 32'h1});
      bus_read(ADDR_STATUS, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0] || Irq !== e[W]) begin
         bad++; $display("FAIL disable_keeps got status=%h irq=%b exp status=%h irq=%b", got, Irq, e[W-1:0], e[W]);
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] got;
      logic [W:0]   e;
      tb_drv[7:0] = 8'hFC;
      repeat (10) @(negedge CK);
      bus_write(ADDR_DIR, 32'hFF);
      tb_oe = ~32'hFF;
      exp_q.push_back({1'b1, 32'hFF});
      bus_read(ADDR_DIR, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0] || Irq !== e[W]) begin
         bad++; $display("FAIL pre_reset got dir=%h irq=%b exp dir=%h irq=%b", got, Irq, e[W-1:0], e[W]);
      end
      #1 RSTN = 1'b0;
      #1;
      total++;
      if (Irq !== 1'b0 || RdData !== '0) begin
         bad++; $display("FAIL async_reset_out got Irq=%b RdData=%h exp 0/0", Irq, RdData);
      end
      tb_drv[7:0] = 8'h03;
      tb_oe = '1;
      #1;
      total++;
      if (GPIO[7:0] !== 8'h03) begin
         bad++; $display("FAIL async_reset_pads got=%h exp=03", GPIO[7:0]);
      end
      @(negedge CK);
      RSTN = 1'b1;
      exp_q.push_back('0);
      exp_q.push_back('0);
      bus_read(ADDR_DIR, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL post_reset_dir got=%h exp=%h", got, e[W-1:0]);
      end
      bus_read(ADDR_STATUS, got);
      e = exp_q.pop_front();
      total++;
      if (got !== e[W-1:0]) begin
         bad++; $display("FAIL post_reset_status got=%h exp=%h", got, e[W-1:0]);
      end
   endtask

   initial begin
      test_reset();
      test_drive();
      test_set_clear();
      test_debounce();
      test_edge_irq();
      test_collision();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
